bike_mult_sched: RTL
====================

// Module: bike_mult_sched
// PURPOSE
//  Sequencer for the sparse-dense polynomial multiplier.
//  - Walks all WEIGHT sparse positions; for each, streams NUM_BLOCKS dense-block reads and the matching accumulator writes.
//  - Issues RAM addresses/strobes only; the rotate/XOR datapath is external.
//  - Non-overlapping schedule: each position drains fully before the next is fetched.
// PARAMETERS
//  WEIGHT      71  sparse positions per polynomial (pos counter 0..WEIGHT-1)
//  NUM_BLOCKS  20  dense blocks per polynomial (block counter 0..NUM_BLOCKS-1, wraps)
//  LOGW        7   width of pos_addr, >= clog2(WEIGHT)
//  LOGB        5   width of dense/acc addresses, >= clog2(NUM_BLOCKS)
//  RAM_LAT     2   read latency of position and dense RAMs, 1..4
// PORTS
//  clk        in   1     system clock, all logic on rising edge
//  resetn     in   1     synchronous, active-low reset
//  start      in   1     request; accepted only in IDLE
//  stall      in   1     datapath back-pressure; sampled only at position boundaries
//  busy       out  1     high from cycle after accepted start until DONE inclusive
//  done       out  1     one-cycle completion pulse
//  pos_ren    out  1     position RAM read strobe
//  pos_addr   out  LOGW  position RAM address
//  pos_latch  out  1     datapath latches position RAM output (RAM_LAT after pos_ren)
//  dense_ren  out  1     dense RAM read strobe
//  dense_addr out  LOGB  dense RAM read address
//  acc_wen    out  1     accumulator write strobe
//  acc_waddr  out  LOGB  accumulator write address
//  acc_init   out  1     qualifies acc_wen: overwrite instead of XOR (position 0 only)
// BEHAVIOUR
//  Reset: state=IDLE; counters=0; delay line cleared; every output 0. Applies mid-operation; no write strobe is emitted after reset.
//  FSM:
//  - IDLE: start=1 -> FETCH.
//  - FETCH: RAM_LAT+1 cycles, local cnt f.
//    - f=0 holds while stall=1; pos_ren=1 only on the cycle it advances (stall=0).
//    - pos_addr=pos counter throughout FETCH.
//    - f=RAM_LAT: pos_latch=1 -> STREAM.
//  - STREAM: NUM_BLOCKS cycles; dense_ren=1, dense_addr=block counter; block counter +1, wraps NUM_BLOCKS-1 -> 0. Last cycle -> DRAIN.
//  - DRAIN: RAM_LAT+1 cycles, waits for write pipeline to empty. Then:
//    - pos<WEIGHT-1: pos+1 -> FETCH.
//    - else: pos=0 -> DONE.
//  - DONE: 1 cycle, done=1 -> IDLE.
//  Write path: {acc_wen,acc_waddr,acc_init} = {dense_ren,dense_addr,pos==0} delayed RAM_LAT+1 cycles (RAM + one datapath stage). Delay line advances every cycle, unconditionally.
//  Timing: start accepted at cycle 0 with stall=0 -> done at cycle 1 + WEIGHT*(2*RAM_LAT+2+NUM_BLOCKS).
//  Stall: adds exactly the stalled cycles per boundary. Never freezes STREAM or DRAIN.
//  Boundaries:
//  - start while busy or in DONE: ignored, no queueing.
//  - start=1 in cycle after done: accepted.
//  - WEIGHT=1: single pass, acc_init high on all writes.
//  - All addresses in range; no address beyond NUM_BLOCKS-1 or WEIGHT-1 is ever driven.
//  - pos_ren and dense_ren never high in same cycle.
// STRUCTURE
//  Package bike_mult_pkg:
//  - typedef enum logic [2:0] {IDLE,FETCH,STREAM,DRAIN,DONE} sched_state_t
//  - clog2-based width helpers; RAM_LAT bound check constant.
//  Sub-module bike_mult_sched_dly: parameterised DEPTH x WIDTH shift register with synchronous active-low clear. Carries the write-path tuple.
//  Top: FSM, pos counter, block counter, FETCH/DRAIN phase counter.
// TESTING (bench params WEIGHT=3, NUM_BLOCKS=4, RAM_LAT=1 unless noted)
//  1 Nominal: start pulse at c0, stall=0 -> done at c25 only.
//    - pos_ren at c1,c9,c17 with pos_addr 0,1,2.
//    - dense_addr 0,1,2,3 at c3..c6.
//    - acc_wen at c5..c8, acc_init=1 there only.
//  2 Stall: hold stall=1 for c9..c13 -> second pos_ren at c14; done at c30.
//  3 Reset mid-STREAM (resetn=0 at c5):
//    - next cycle all outputs 0, no acc_wen afterwards.
//    - fresh start runs as test 1.
//  4 Start during busy at c10 and c20 ignored -> single done at c25.
//    - start=1 at c26 -> second done at c51.
//  5 Defaults (71/20/2) -> done at exactly cycle 1+71*26=1847.
//    - 1420 acc_wen pulses total.
//    - addresses in range; pos_ren and dense_ren never overlap.

Source files
------------

// File: rtl/bike_mult_pkg.sv
// -----------------------------------------------------------------------------
// bike_mult_pkg
// Shared types and constants for the sparse-dense multiplier sequencer.
//  - sched_state_t : sequencer FSM encoding
//  - RAM_LAT_MIN/MAX, PHASE_W : legal RAM read latency range and the width of
//    the FETCH/DRAIN phase counter that covers it
//  - ram_lat_ok / width_fits : elaboration-time parameter sanity checks
//  - dly_width : width of the write-path tuple {wen, waddr, init}
// -----------------------------------------------------------------------------
package bike_mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    STREAM,
    DRAIN,
    DONE
  } sched_state_t;

  localparam int unsigned RAM_LAT_MIN = 1;
  localparam int unsigned RAM_LAT_MAX = 4;
  // Phase counter runs 0..RAM_LAT, so it must hold RAM_LAT_MAX.
  localparam int unsigned PHASE_W = $clog2(RAM_LAT_MAX + 1);

  function automatic bit ram_lat_ok(input int unsigned lat);
    return (lat >= RAM_LAT_MIN) && (lat <= RAM_LAT_MAX);
  endfunction

  // True when a w-bit counter can address n entries (0..n-1).
  function automatic bit width_fits(input int unsigned w, input int unsigned n);
    return (n <= 1) || ($clog2(n) <= w);
  endfunction

  function automatic int unsigned dly_width(input int unsigned logb);
    return logb + 2;
  endfunction

endpackage

// File: rtl/bike_mult_sched_dly.sv
// -----------------------------------------------------------------------------
// bike_mult_sched_dly
// DEPTH-stage, WIDTH-bit shift register with synchronous active-low clear.
// Carries the accumulator write tuple alongside the RAM + datapath latency.
// Ports:
//  clk     in   1      clock
//  resetn  in   1      synchronous active-low clear of every stage
//  d_i     in   WIDTH  stage 0 input, shifted in every cycle
//  q_o     out  WIDTH  output of the last stage (d_i delayed DEPTH cycles)
// -----------------------------------------------------------------------------
module bike_mult_sched_dly
  import bike_mult_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] stage_q;
    logic [WIDTH-1:0] stage_d;

    if (gi == 0) begin : g_head
      assign stage_d = d_i;
    end else begin : g_tail
      assign stage_d = g_stage[gi-1].stage_q;
    end

    always_ff @(posedge clk) begin
      if (!resetn) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end
  end

  assign q_o = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/bike_mult_sched.sv
// -----------------------------------------------------------------------------
// bike_mult_sched
// Address/strobe sequencer for the sparse-dense polynomial multiplier. For each
// of WEIGHT sparse positions it fetches the position, streams NUM_BLOCKS dense
// reads, then drains the write pipeline before moving on (no overlap).
// Ports:
//  clk, resetn           clock, synchronous active-low reset
//  start                 run request, honoured only in IDLE
//  stall                 back-pressure, looked at only while waiting to fetch
//  busy / done           run in progress (incl. DONE) / one-cycle completion
//  pos_ren, pos_addr     position RAM read
//  pos_latch             datapath captures position RAM data
//  dense_ren, dense_addr dense RAM read
//  acc_wen, acc_waddr    accumulator write (dense read delayed RAM_LAT+1)
//  acc_init              write overwrites rather than XORs (position 0)
// -----------------------------------------------------------------------------
module bike_mult_sched
  import bike_mult_pkg::*;
#(
  parameter int unsigned WEIGHT     = 71,
  parameter int unsigned NUM_BLOCKS = 20,
  parameter int unsigned LOGW       = 7,
  parameter int unsigned LOGB       = 5,
  parameter int unsigned RAM_LAT    = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            stall,
  output logic            busy,
  output logic            done,
  output logic            pos_ren,
  output logic [LOGW-1:0] pos_addr,
  output logic            pos_latch,
  output logic            dense_ren,
  output logic [LOGB-1:0] dense_addr,
  output logic            acc_wen,
  output logic [LOGB-1:0] acc_waddr,
  output logic            acc_init
);

  if (!ram_lat_ok(RAM_LAT)) begin : g_bad_ram_lat
    $error("bike_mult_sched: RAM_LAT out of range");
  end
  if (!width_fits(LOGW, WEIGHT) || !width_fits(LOGB, NUM_BLOCKS)) begin : g_bad_width
    $error("bike_mult_sched: LOGW/LOGB too narrow");
  end

  localparam int unsigned DLY_W = dly_width(LOGB);
  localparam logic [LOGW-1:0]    POS_LAST = LOGW'(WEIGHT - 1);
  localparam logic [LOGB-1:0]    BLK_LAST = LOGB'(NUM_BLOCKS - 1);
  localparam logic [PHASE_W-1:0] PH_LAST  = PHASE_W'(RAM_LAT);

  sched_state_t       state_q, state_d;
  logic [LOGW-1:0]    pos_q, pos_d;
  logic [LOGB-1:0]    blk_q, blk_d;
  logic [PHASE_W-1:0] ph_q, ph_d;   // shared FETCH/DRAIN phase counter
  logic [DLY_W-1:0]   wr_tuple;
  logic [DLY_W-1:0]   wr_tuple_dly;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      pos_q   <= '0;
      blk_q   <= '0;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      blk_q   <= blk_d;
      ph_q    <= ph_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    blk_d      = blk_q;
    ph_d       = ph_q;
    busy       = (state_q != IDLE);
    done       = 1'b0;
    pos_ren    = 1'b0;
    pos_addr   = '0;
    pos_latch  = 1'b0;
    dense_ren  = 1'b0;
    dense_addr = '0;

    unique case (state_q)
      IDLE: begin
        ph_d = '0;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        pos_addr = pos_q;
        if (ph_q == '0) begin
          // Stall only holds the fetch issue; the read fires on the advancing cycle.
          if (!stall) begin
            pos_ren = 1'b1;
            ph_d    = ph_q + 1'b1;
          end
        end else if (ph_q == PH_LAST) begin
          pos_latch = 1'b1;
          ph_d      = '0;
          state_d   = STREAM;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      STREAM: begin
        dense_ren  = 1'b1;
        dense_addr = blk_q;
        if (blk_q == BLK_LAST) begin
          blk_d   = '0;
          state_d = DRAIN;
        end else begin
          blk_d = blk_q + 1'b1;
        end
      end
      DRAIN: begin
        // Last dense read's write leaves the delay line after RAM_LAT+1 cycles.
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (pos_q == POS_LAST) begin
            pos_d   = '0;
            state_d = DONE;
          end else begin
            pos_d   = pos_q + 1'b1;
            state_d = FETCH;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // init is qualified by the read strobe so it never shows without a write.
  assign wr_tuple = {dense_ren, dense_addr, dense_ren & (pos_q == '0)};

  bike_mult_sched_dly #(
    .DEPTH (RAM_LAT + 1),
    .WIDTH (DLY_W)
  ) u_wr_dly (
    .clk    (clk),
    .resetn (resetn),
    .d_i    (wr_tuple),
    .q_o    (wr_tuple_dly)
  );

  assign {acc_wen, acc_waddr, acc_init} = wr_tuple_dly;

endmodule
